// File: rtl/fft_frame_tx_if.sv
// Sample-stream and FFT-input signal bundle for the ping-pong frame transmitter.
// slave is the transmitter's view; master is the source/FFT side.
interface fft_frame_tx_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              fft_in_push;
  logic              fft_in_stall;
  logic [DATA_W-1:0] fft_in_real;
  logic [DATA_W-1:0] fft_in_imag;

  modport slave (
    input  s_valid, s_real, s_imag, fft_in_stall,
    output s_ready, fft_in_push, fft_in_real, fft_in_imag
  );

  modport master (
    output s_valid, s_real, s_imag, fft_in_stall,
    input  s_ready, fft_in_push, fft_in_real, fft_in_imag
  );
endinterface

// File: rtl/fft_frame_tx.sv
// Ping-pong frame buffer: collects FRAME_LEN samples, then streams the frame to the FFT in index order.
// Push rises the cycle after the last sample of a frame; s_ready drops only when both buffers are FULL.
module fft_frame_tx #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  fft_frame_tx_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;

  buf_state_t       state_q [2];
  buf_state_t       state_d [2];
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  sample_t          mem [2][FRAME_LEN];
  sample_t          rd_smp;

  logic wr_rdy;
  logic rd_push;
  logic wr_acc;
  logic rd_xfer;
  logic wr_last;
  logic rd_last;

  // Reset gating keeps the handshake outputs quiet for the whole reset window.
  assign wr_rdy  = !reset && (state_q[wr_sel] != FULL);
  assign rd_push = !reset && (state_q[rd_sel] == FULL);
  assign wr_acc  = bus.s_valid && wr_rdy;
  assign rd_xfer = rd_push && !bus.fft_in_stall;
  assign wr_last = wr_acc && (wr_cnt == LAST_IDX);
  assign rd_last = rd_xfer && (rd_cnt == LAST_IDX);

  assign bus.s_ready     = wr_rdy;
  assign bus.fft_in_push = rd_push;
  assign rd_smp          = mem[rd_sel][rd_cnt];
  assign bus.fft_in_real = rd_smp.re;
  assign bus.fft_in_imag = rd_smp.im;
  assign busy            = !reset && ((state_q[0] != EMPTY) || (state_q[1] != EMPTY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // A write can only touch a non-FULL buffer and a read only a FULL one, so the two never collide.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (wr_acc) begin
      state_d[wr_sel] = wr_last ? FULL : FILLING;
    end
    if (rd_last) begin
      state_d[rd_sel] = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      frames_sent <= '0;
    end else begin
      if (wr_acc) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + IDX_W'(1);
        if (wr_last) begin
          wr_sel <= ~wr_sel;
        end
      end
      if (rd_xfer) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + IDX_W'(1);
        if (rd_last) begin
          rd_sel      <= ~rd_sel;
          frames_sent <= frames_sent + CNT_W'(1);
        end
      end
    end
  end

  // Only entry 0 of buffer 0 is cleared, so the idle data outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_sel][wr_cnt] <= {bus.s_real, bus.s_imag};
    end
    if (reset) begin
      mem[0][0] <= '0;
    end
  end
endmodule
